// File: rtl/ctx_mem_pkg.sv
// Shared types and address helper for the context-memory responder.
package ctx_mem_pkg;

    typedef logic [31:0] ctx_mem_word_t;

    localparam ctx_mem_word_t CTX_MEM_ERR_DATA = 32'hDEAD_BEEF;

    typedef struct packed {
        logic          valid;
        ctx_mem_word_t data;
    } ctx_mem_rsp_t;

    // off is the byte offset from the window base; the base is window-aligned,
    // so off[1:0] equals the request's own low address bits.
    function automatic logic ctx_mem_in_window(input logic [31:0] off, input int unsigned aw);
        return (off < (32'd4 << aw)) && (off[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/ctx_mem_rd_pipe.sv
// Fixed-latency read response delay line; each stage's data moves only with its valid bit.
module ctx_mem_rd_pipe
    import ctx_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  ctx_mem_rsp_t rsp_i,
    output ctx_mem_rsp_t rsp_o
);

    logic [DEPTH-1:0] vld_pipe;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= rsp_i.valid;
            for (int i = 1; i < DEPTH; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        ctx_mem_word_t d_in;
        ctx_mem_word_t d_q;
        logic          ld;

        if (g == 0) begin : g_head
            assign ld   = rsp_i.valid;
            assign d_in = rsp_i.data;
        end else begin : g_body
            assign ld   = vld_pipe[g-1];
            assign d_in = g_stage[g-1].d_q;
        end

        // Output stage data also resets so the data port has a defined value out of reset.
        if (g == DEPTH - 1) begin : g_out
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni)  d_q <= '0;
                else if (ld)  d_q <= d_in;
            end
        end else begin : g_mid
            always_ff @(posedge clk_i) begin
                if (ld) d_q <= d_in;
            end
        end
    end

    assign rsp_o = '{valid: vld_pipe[DEPTH-1], data: g_stage[DEPTH-1].d_q};

endmodule

// File: rtl/ctx_mem_responder.sv
// Context-memory responder: word store, address decode, in-order read pipe, traffic/error counters.
module ctx_mem_responder
    import ctx_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0001_0000,
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        ctx_mem_wr_en_i,
    input  logic [31:0] ctx_mem_wr_addr_i,
    input  logic [31:0] ctx_mem_wr_data_i,
    input  logic        ctx_mem_rd_rq_valid_i,
    input  logic [31:0] ctx_mem_rd_rq_addr_i,
    output logic        ctx_mem_rd_resp_valid_o,
    output logic [31:0] ctx_mem_rd_data_o,
    output logic        err_o,
    input  logic        err_clr_i,
    output logic [31:0] wr_count_o,
    output logic [31:0] rd_count_o
);

    localparam int unsigned WORDS = 1 << ADDR_WIDTH;

    ctx_mem_word_t mem [WORDS];

    logic [31:0]           wr_off, rd_off;
    logic                  wr_ok, rd_ok;
    logic [ADDR_WIDTH-1:0] wr_idx, rd_idx;
    logic                  wr_hit;
    ctx_mem_rsp_t          rd_rsp, pipe_rsp;

    assign wr_off = ctx_mem_wr_addr_i - BASE_ADDR;
    assign rd_off = ctx_mem_rd_rq_addr_i - BASE_ADDR;
    assign wr_ok  = ctx_mem_in_window(wr_off, ADDR_WIDTH);
    assign rd_ok  = ctx_mem_in_window(rd_off, ADDR_WIDTH);
    assign wr_idx = wr_off[ADDR_WIDTH+1:2];
    assign rd_idx = rd_off[ADDR_WIDTH+1:2];
    assign wr_hit = ctx_mem_wr_en_i && wr_ok;

    // Store is deliberately outside reset: context survives a responder reset.
    always_ff @(posedge clk_i) begin
        if (wr_hit) mem[wr_idx] <= ctx_mem_wr_data_i;
    end

    // Read data is captured at the request edge; a same-cycle write to the word wins.
    always_comb begin
        rd_rsp.valid = ctx_mem_rd_rq_valid_i;
        if (!rd_ok)                        rd_rsp.data = CTX_MEM_ERR_DATA;
        else if (wr_hit && wr_idx == rd_idx) rd_rsp.data = ctx_mem_wr_data_i;
        else                               rd_rsp.data = mem[rd_idx];
    end

    ctx_mem_rd_pipe #(.DEPTH(RD_LATENCY)) u_rd_pipe (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .rsp_i  (rd_rsp),
        .rsp_o  (pipe_rsp)
    );

    assign ctx_mem_rd_resp_valid_o = pipe_rsp.valid;
    assign ctx_mem_rd_data_o       = pipe_rsp.data;

    // A new error in the clear cycle keeps the flag set.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_o      <= 1'b0;
            wr_count_o <= '0;
            rd_count_o <= '0;
        end else begin
            if (ctx_mem_wr_en_i)       wr_count_o <= wr_count_o + 32'd1;
            if (ctx_mem_rd_rq_valid_i) rd_count_o <= rd_count_o + 32'd1;
            if ((ctx_mem_wr_en_i && !wr_ok) || (ctx_mem_rd_rq_valid_i && !rd_ok))
                err_o <= 1'b1;
            else if (err_clr_i)
                err_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ctx_mem_responder.sv
// Directed bench for ctx_mem_responder at read latencies 2, 1 and 8 with a response scoreboard.
module tb_ctx_mem_responder;
    localparam logic [31:0] BASE = 32'h0001_0000;
    localparam int LAT [3] = '{2, 1, 8};

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0, rd_en = 1'b0, err_clr = 1'b0;
    logic [31:0] wr_addr = '0, wr_data = '0, rd_addr = '0;
    logic [2:0]        rv, ev;
    logic [2:0][31:0]  rd, wc, rc;

    int n_assert = 0, n_fail = 0, cyc = 0;
    int wr_cnt = 0, rd_cnt = 0;
    logic err_exp = 1'b0;
    logic [31:0] model [logic [31:0]];
    exp_t q [3][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ctx_mem_responder #(.RD_LATENCY(2)) u_l2 (
        .clk_i(clk), .rst_ni(rst_n), .ctx_mem_wr_en_i(wr_en), .ctx_mem_wr_addr_i(wr_addr),
        .ctx_mem_wr_data_i(wr_data), .ctx_mem_rd_rq_valid_i(rd_en), .ctx_mem_rd_rq_addr_i(rd_addr),
        .ctx_mem_rd_resp_valid_o(rv[0]), .ctx_mem_rd_data_o(rd[0]), .err_o(ev[0]),
        .err_clr_i(err_clr), .wr_count_o(wc[0]), .rd_count_o(rc[0]));
    ctx_mem_responder #(.RD_LATENCY(1)) u_l1 (
        .clk_i(clk), .rst_ni(rst_n), .ctx_mem_wr_en_i(wr_en), .ctx_mem_wr_addr_i(wr_addr),
        .ctx_mem_wr_data_i(wr_data), .ctx_mem_rd_rq_valid_i(rd_en), .ctx_mem_rd_rq_addr_i(rd_addr),
        .ctx_mem_rd_resp_valid_o(rv[1]), .ctx_mem_rd_data_o(rd[1]), .err_o(ev[1]),
        .err_clr_i(err_clr), .wr_count_o(wc[1]), .rd_count_o(rc[1]));
    ctx_mem_responder #(.RD_LATENCY(8)) u_l8 (
        .clk_i(clk), .rst_ni(rst_n), .ctx_mem_wr_en_i(wr_en), .ctx_mem_wr_addr_i(wr_addr),
        .ctx_mem_wr_data_i(wr_data), .ctx_mem_rd_rq_valid_i(rd_en), .ctx_mem_rd_rq_addr_i(rd_addr),
        .ctx_mem_rd_resp_valid_o(rv[2]), .ctx_mem_rd_data_o(rd[2]), .err_o(ev[2]),
        .err_clr_i(err_clr), .wr_count_o(wc[2]), .rd_count_o(rc[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic in_win(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (off < 32'd4096) && (a[1:0] == 2'b00);
    endfunction

    // Response monitor: every valid pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rv[k]) begin
                if (q[k].size() == 0) begin
                    chk($sformatf("spurious_rsp_l%0d", LAT[k]), {31'b0, rv[k]}, 32'd0);
                end else begin
                    exp_t e;
                    e = q[k].pop_front();
                    chk($sformatf("rsp_data_l%0d", LAT[k]), rd[k], e.data);
                    chk($sformatf("rsp_lat_l%0d", LAT[k]), 32'(cyc - e.cyc), 32'(LAT[k]));
                end
            end
        end
    end

    task automatic drive(input logic we, input logic [31:0] wa, input logic [31:0] wd,
                         input logic re, input logic [31:0] ra, input logic clr);
        logic new_err;
        exp_t e;
        @(posedge clk); #1;
        wr_en = we; wr_addr = wa; wr_data = wd; rd_en = re; rd_addr = ra; err_clr = clr;
        new_err = 1'b0;
        if (re) begin
            if (!in_win(ra)) begin
                e.data = 32'hDEAD_BEEF;
                new_err = 1'b1;
            end else if (we && in_win(wa) && wa == ra) begin
                e.data = wd;
            end else begin
                e.data = model.exists(ra) ? model[ra] : 32'h0;
            end
            e.cyc = cyc;
            for (int k = 0; k < 3; k++) q[k].push_back(e);
            rd_cnt++;
        end
        if (we) begin
            wr_cnt++;
            if (in_win(wa)) model[wa] = wd;
            else new_err = 1'b1;
        end
        err_exp = (err_exp && !clr) || new_err;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
        end
    endtask

    task automatic chk_regs(input string tag);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s_wrcnt_l%0d", tag, LAT[k]), wc[k], 32'(wr_cnt));
            chk($sformatf("%s_rdcnt_l%0d", tag, LAT[k]), rc[k], 32'(rd_cnt));
            chk($sformatf("%s_err_l%0d", tag, LAT[k]), {31'b0, ev[k]}, {31'b0, err_exp});
        end
    endtask

    task automatic chk_reset_state(input string tag);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s_valid_l%0d", tag, LAT[k]), {31'b0, rv[k]}, 32'd0);
            chk($sformatf("%s_data_l%0d", tag, LAT[k]), rd[k], 32'd0);
        end
    endtask

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        chk_regs("rst0");
        chk_reset_state("rst0");
        @(posedge clk); #1 rst_n = 1'b1;

        // Basic write then read; latency checked per instance by the monitor
        drive(1'b1, BASE + 8, 32'hCAFE_0001, 1'b0, '0, 1'b0);
        drive(1'b0, '0, '0, 1'b1, BASE + 8, 1'b0);
        idle(1);
        chk_regs("s1");
        idle(10);
        @(negedge clk);
        for (int k = 0; k < 3; k++) chk($sformatf("s1_hold_l%0d", LAT[k]), rd[k], 32'hCAFE_0001);

        // Write-first bypass, and a later write must not disturb a pending read
        drive(1'b1, BASE + 4, 32'h1234_5678, 1'b1, BASE + 4, 1'b0);
        drive(1'b0, '0, '0, 1'b1, BASE + 4, 1'b0);
        drive(1'b1, BASE + 4, 32'hAAAA_AAAA, 1'b0, '0, 1'b0);
        drive(1'b0, '0, '0, 1'b1, BASE + 4, 1'b0);
        idle(10);

        // Back-to-back reads of an index-preloaded region
        for (int i = 0; i < 16; i++) drive(1'b1, BASE + 32'(4 * i), 32'(i), 1'b0, '0, 1'b0);
        for (int i = 0; i < 16; i++) drive(1'b0, '0, '0, 1'b1, BASE + 32'(4 * i), 1'b0);
        idle(1);
        chk_regs("s3");
        idle(10);

        // Out-of-window / misaligned accesses and the error flag
        drive(1'b0, '0, '0, 1'b1, BASE - 4, 1'b0);
        drive(1'b0, '0, '0, 1'b1, BASE + 2, 1'b0);
        drive(1'b1, BASE + 32'd4096, 32'h5555_5555, 1'b0, '0, 1'b0);
        idle(1);
        chk_regs("s4_err");
        drive(1'b0, '0, '0, 1'b1, BASE, 1'b0);
        drive(1'b0, '0, '0, 1'b0, '0, 1'b1);
        idle(1);
        chk_regs("s4_clr");
        drive(1'b0, '0, '0, 1'b1, BASE - 4, 1'b1);
        idle(1);
        chk_regs("s4_clrset");
        idle(10);

        // Reset with reads in flight; store must persist
        drive(1'b1, BASE + 8, 32'hCAFE_0001, 1'b0, '0, 1'b0);
        idle(10);
        drive(1'b0, '0, '0, 1'b1, BASE + 8, 1'b0);
        drive(1'b0, '0, '0, 1'b1, BASE, 1'b0);
        drive(1'b0, '0, '0, 1'b1, BASE + 4, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
        for (int k = 0; k < 3; k++) q[k].delete();
        wr_cnt = 0; rd_cnt = 0; err_exp = 1'b0;
        chk_regs("s5_rst");
        chk_reset_state("s5_rst");
        @(posedge clk); #1 rst_n = 1'b1;
        idle(3);
        drive(1'b0, '0, '0, 1'b1, BASE + 8, 1'b0);
        idle(1);
        chk_regs("s5_after");

        // Drain with a bounded wait, then every expected response must have arrived
        for (int i = 0; i < 30 && (q[0].size() + q[1].size() + q[2].size()) != 0; i++)
            @(negedge clk);
        for (int k = 0; k < 3; k++)
            chk($sformatf("drain_l%0d", LAT[k]), 32'(q[k].size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
